// File: rtl/nn_mem_pkg.sv
// Shared types and constants for the on-chip NN memory and its access engines.
package nn_mem_pkg;
  localparam int MEM_WORDS = 37500;

  typedef logic [15:0] addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } brd_state_t;
endpackage

// File: rtl/ram_rd_fifo.sv
// First-word-fall-through FIFO: head is visible combinationally whenever non-empty.
// Push and pop in the same cycle leave the count unchanged; writes when full are dropped.
module ram_rd_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nRST,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  // Extra pointer bit distinguishes full from empty.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: fetches length words from base_addr and streams them over valid/ready.
// First word 3 cycles after start, then 1 word/cycle; reads throttle so the FIFO never overruns.
module ram_burst_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MEM_WORDS  = nn_mem_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  import nn_mem_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  brd_state_t        state;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              rd_pending;
  logic [ADDR_W:0]   end_addr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;

  assign end_addr = {1'b0, base_addr} + {1'b0, length};
  assign pop      = out_valid && out_ready;

  // Data for a read issued now lands one cycle after rd_pending's, so count + rd_pending bounds occupancy.
  assign ram_ren  = (state == RUN) && (remaining != '0) && !fifo_full &&
                    ((int'(fifo_count) + int'(rd_pending)) < FIFO_DEPTH);
  assign ram_addr = ram_ren ? next_addr : last_addr;

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      remaining  <= '0;
      next_addr  <= '0;
      last_addr  <= '0;
      rd_pending <= 1'b0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      rd_pending <= ram_ren;
      case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else if (end_addr > (ADDR_W+1)'(MEM_WORDS)) begin
              err <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              remaining <= length;
              next_addr <= base_addr;
            end
          end
        end
        RUN: begin
          if (ram_ren) begin
            last_addr <= next_addr;
            next_addr <= next_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == ADDR_W'(1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (fifo_count == CNT_W'(1)) && !rd_pending) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_rd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nRST      (nRST),
    .push      (rd_pending),
    .push_data (ram_dout),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;
endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: 1-cycle-latency RAM model holding mem[i]=i*3+1, table plus random bursts.
module tb_ram_burst_reader;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MEMW  = 37500;

  logic          clk = 1'b0;
  logic          nRST;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic          busy, done, err, ram_ren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  ram_burst_reader #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MEMW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .nRST(nRST), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err), .ram_ren(ram_ren), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_word(input int unsigned a);
    return DW'(a * 3 + 1);
  endfunction

  always @(posedge clk) begin
    if (ram_ren)
      ram_dout <= ref_word(int'(ram_addr));
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Observer: read counting, accepted-word capture, pulse counts, stall stability.
  int            ren_cnt, done_cnt, err_cnt;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] got[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (nRST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (ram_ren) begin
        ren_cnt++;
        last_addr = ram_addr;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      done_cnt += int'(done);
      err_cnt  += int'(err);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // mode 0: ready always 1; mode 1: ready 0 for 10 cycles then 1; mode 2: random ready.
  task automatic run_burst(input int base, input int len, input int mode,
                           output int first, output logic busy1);
    logic timed_out;
    got.delete();
    ren_cnt = 0; done_cnt = 0; err_cnt = 0; first = -1; busy1 = 1'b0;
    timed_out = 1'b1;
    @(posedge clk); #1;
    base_addr = AW'(base); length = AW'(len); start = 1'b1;
    out_ready = (mode != 1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (first < 0 && (out_valid || done || err)) first = k;
      if (k == 1) busy1 = busy;
      if (mode == 1 && k == 10) begin
        check("stall_reads", ren_cnt, DEPTH);
        check("stall_ren_low", ram_ren, 0);
        out_ready = 1'b1;
      end
      if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      if (done_cnt + err_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (timed_out) check("burst_timeout", 1, 0);
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_result(input int base, input int len, input int exp_done,
                              input int exp_err, input int exp_reads, input int exp_last);
    int nwords;
    nwords = (exp_done == 1) ? len : 0;
    check("done_count", done_cnt, exp_done);
    check("err_count", err_cnt, exp_err);
    check("read_count", ren_cnt, exp_reads);
    if (exp_reads > 0) check("last_addr", last_addr, exp_last);
    check("word_count", got.size(), nwords);
    for (int i = 0; i < nwords && i < got.size(); i++)
      check($sformatf("word[%0d]", i), got[i], ref_word(base + i));
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
  endtask

  typedef struct {
    int   base;
    int   len;
    int   mode;
    int   exp_done;
    int   exp_err;
    int   exp_reads;
    int   exp_last;
    int   exp_first;
    logic exp_busy1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int   first;
    logic busy1;
    int   base;
    int   len;

    tbl[0] = '{base: 10,    len: 5, mode: 0, exp_done: 1, exp_err: 0, exp_reads: 5, exp_last: 14,    exp_first: 3, exp_busy1: 1'b1};
    tbl[1] = '{base: 0,     len: 8, mode: 1, exp_done: 1, exp_err: 0, exp_reads: 8, exp_last: 7,     exp_first: 3, exp_busy1: 1'b1};
    tbl[2] = '{base: 5,     len: 0, mode: 0, exp_done: 1, exp_err: 0, exp_reads: 0, exp_last: 0,     exp_first: 1, exp_busy1: 1'b0};
    tbl[3] = '{base: 37495, len: 6, mode: 0, exp_done: 0, exp_err: 1, exp_reads: 0, exp_last: 0,     exp_first: 1, exp_busy1: 1'b0};
    tbl[4] = '{base: 37495, len: 5, mode: 0, exp_done: 1, exp_err: 0, exp_reads: 5, exp_last: 37499, exp_first: 3, exp_busy1: 1'b1};

    nRST = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ren", ram_ren, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    nRST = 1'b0;

    foreach (tbl[i]) begin
      run_burst(tbl[i].base, tbl[i].len, tbl[i].mode, first, busy1);
      check($sformatf("first_cycle[%0d]", i), first, tbl[i].exp_first);
      check($sformatf("busy_cycle1[%0d]", i), busy1, tbl[i].exp_busy1);
      check_result(tbl[i].base, tbl[i].len, tbl[i].exp_done, tbl[i].exp_err,
                   tbl[i].exp_reads, tbl[i].exp_last);
    end

    for (int r = 0; r < 4; r++) begin
      len  = (r == 0) ? 100 : $urandom_range(1, 60);
      base = $urandom_range(0, MEMW - len);
      run_burst(base, len, 2, first, busy1);
      check_result(base, len, 1, 0, len, base + len - 1);
    end

    // Reset four cycles into a burst, then a clean burst afterwards.
    @(posedge clk); #1;
    base_addr = 16'd200; length = 16'd20; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    done_cnt = 0; err_cnt = 0;
    nRST = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ren", ram_ren, 0);
    check("mid_rst_addr", ram_addr, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    nRST = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("post_rst_valid", out_valid, 0);
    check("post_rst_pulses", done_cnt + err_cnt, 0);
    run_burst(500, 6, 0, first, busy1);
    check("post_rst_first", first, 3);
    check_result(500, 6, 1, 0, 6, 505);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
